// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: cache miss sequencer that owns the fetch side of a
// word-wide memory controller. Each accepted miss request can first write
// back a dirty victim line, one word at a time, from the cache data array to
// memory. It then refills the same cache line from memory and pulses done.
// Only one line operation is in flight at a time.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_*             miss request handshake and request fields
//   done              one-cycle pulse when a line operation completes
//   cache_r*          cache array read port (data returns 1 cycle after ren)
//   cache_w*          cache array write port
//   mem_r*            memory read request/accept and returned data/valid
//   mem_w*            memory write request/accept
module line_fill_ctrl #(
    parameter int MEM_DEPTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int LINE_WORDS  = 4,
    parameter int CACHE_DEPTH = 16,
    localparam int MAW = $clog2(MEM_DEPTH),
    localparam int OFS = $clog2(LINE_WORDS),
    localparam int CAW = $clog2(CACHE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CAW-OFS-1:0]    req_set,
    input  logic [MAW-OFS-1:0]    req_fill_line,
    input  logic                  req_wb,
    input  logic [MAW-OFS-1:0]    req_wb_line,
    output logic                  done,
    output logic                  cache_ren,
    output logic [CAW-1:0]        cache_raddr,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  cache_wen,
    output logic [CAW-1:0]        cache_waddr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  mem_ren,
    output logic [MAW-1:0]        mem_raddr,
    input  logic                  mem_rready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rdata_valid,
    output logic                  mem_wen,
    output logic [MAW-1:0]        mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_wready
);

    localparam logic [OFS-1:0] LAST_IDX = OFS'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_RD,
        ST_WB_LAT,
        ST_WB_WR,
        ST_FILL_REQ,
        ST_FILL_WAIT,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [OFS-1:0]          idx_q, idx_d;
    logic [CAW-OFS-1:0]      set_q, set_d;
    logic [MAW-OFS-1:0]      fill_line_q, fill_line_d;
    logic [MAW-OFS-1:0]      wb_line_q, wb_line_d;
    logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;

    logic                    idx_last;

    assign idx_last = (idx_q == LAST_IDX);

    // Addresses are always formed from the captured line fields and the word
    // index, so they stay stable for as long as a strobe is held under
    // backpressure. The word index is only OFS bits wide and cannot carry
    // into the set/line field.
    assign cache_raddr = {set_q, idx_q};
    assign cache_waddr = {set_q, idx_q};
    assign mem_waddr   = {wb_line_q, idx_q};
    assign mem_raddr   = {fill_line_q, idx_q};
    assign mem_wdata   = wb_data_q;
    // Fill data goes straight from the memory return bus into the cache array.
    assign cache_wdata = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            set_q       <= '0;
            fill_line_q <= '0;
            wb_line_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            set_q       <= set_d;
            fill_line_q <= fill_line_d;
            wb_line_q   <= wb_line_d;
            wb_data_q   <= wb_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        set_d       = set_q;
        fill_line_d = fill_line_q;
        wb_line_d   = wb_line_q;
        wb_data_d   = wb_data_q;
        req_ready   = 1'b0;
        done        = 1'b0;
        cache_ren   = 1'b0;
        cache_wen   = 1'b0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    set_d       = req_set;
                    fill_line_d = req_fill_line;
                    wb_line_d   = req_wb_line;
                    idx_d       = '0;
                    // The dirty flag is consumed here: it only selects
                    // whether the sequence starts with a writeback.
                    state_d     = req_wb ? ST_WB_RD : ST_FILL_REQ;
                end
            end

            ST_WB_RD: begin
                cache_ren = 1'b1;
                state_d   = ST_WB_LAT;
            end

            ST_WB_LAT: begin
                // Cache read data is only valid this one cycle; hold it
                // locally so the memory write can stall indefinitely.
                wb_data_d = cache_rdata;
                state_d   = ST_WB_WR;
            end

            ST_WB_WR: begin
                mem_wen = 1'b1;
                if (mem_wready) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = ST_FILL_REQ;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_WB_RD;
                    end
                end
            end

            ST_FILL_REQ: begin
                mem_ren = 1'b1;
                if (mem_rready) begin
                    state_d = ST_FILL_WAIT;
                end
            end

            ST_FILL_WAIT: begin
                if (mem_rdata_valid) begin
                    cache_wen = 1'b1;
                    if (idx_last) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_FILL_REQ;
                    end
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Testbench for line_fill_ctrl: memory and cache array models act as slaves,
// a reference model predicts the writeback/fill transaction lists, final
// array contents and completion latency of every line operation.
module tb_line_fill_ctrl;

    localparam int MEM_DEPTH   = 32;
    localparam int DW          = 32;
    localparam int LW          = 4;
    localparam int CACHE_DEPTH = 16;
    localparam int MAW   = $clog2(MEM_DEPTH);
    localparam int OFS   = $clog2(LW);
    localparam int CAW   = $clog2(CACHE_DEPTH);
    localparam int SETW  = CAW - OFS;
    localparam int LINEW = MAW - OFS;

    typedef logic [MAW+DW-1:0] wrec_t;
    typedef logic [CAW+DW-1:0] crec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [SETW-1:0]   req_set = '0;
    logic [LINEW-1:0]  req_fill_line = '0;
    logic              req_wb = 1'b0;
    logic [LINEW-1:0]  req_wb_line = '0;
    logic              done;
    logic              cache_ren;
    logic [CAW-1:0]    cache_raddr;
    logic [DW-1:0]     cache_rdata;
    logic              cache_wen;
    logic [CAW-1:0]    cache_waddr;
    logic [DW-1:0]     cache_wdata;
    logic              mem_ren;
    logic [MAW-1:0]    mem_raddr;
    logic              mem_rready = 1'b1;
    logic [DW-1:0]     mem_rdata;
    logic              mem_rdata_valid;
    logic              mem_wen;
    logic [MAW-1:0]    mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_wready = 1'b1;

    line_fill_ctrl #(
        .MEM_DEPTH(MEM_DEPTH), .DATA_WIDTH(DW), .LINE_WORDS(LW), .CACHE_DEPTH(CACHE_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
        .req_fill_line(req_fill_line), .req_wb(req_wb), .req_wb_line(req_wb_line),
        .done(done),
        .cache_ren(cache_ren), .cache_raddr(cache_raddr), .cache_rdata(cache_rdata),
        .cache_wen(cache_wen), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rready(mem_rready),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wready(mem_wready)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Slave arrays and reference-model copies
    logic [DW-1:0] mem_arr     [MEM_DEPTH];
    logic [DW-1:0] cache_arr   [CACHE_DEPTH];
    logic [DW-1:0] model_mem   [MEM_DEPTH];
    logic [DW-1:0] model_cache [CACHE_DEPTH];

    // Stimulus controls
    bit rand_stall = 0;
    bit spur_idle  = 0;
    bit spur_wb    = 0;
    bit spur       = 0;
    int w_idx = -1, w_left = 0, r_idx = -1, r_left = 0;

    // Observations
    int cyc = 0;
    int acc_cnt, acc_cyc, done_cnt, done_cyc, busy_cnt, stall_cyc;
    int n_wacc, n_racc, excl_err, stab_err;
    bit prev_wstall, prev_rstall;
    logic [MAW-1:0] pw_addr, pr_addr;
    logic [DW-1:0]  pw_data;
    wrec_t wq[$], exp_wq[$];
    logic [MAW-1:0] rq[$], exp_rq[$];
    crec_t cq[$], exp_cq[$];
    int exp_lat;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cache_ren) cache_rdata <= cache_arr[cache_raddr];
        else           cache_rdata <= $urandom;
        if (cache_wen) cache_arr[cache_waddr] <= cache_wdata;
        if (mem_wen && mem_wready) mem_arr[mem_waddr] <= mem_wdata;
        if (mem_ren && mem_rready) begin
            mem_rdata       <= mem_arr[mem_raddr];
            mem_rdata_valid <= 1'b1;
        end else begin
            mem_rdata       <= $urandom;
            mem_rdata_valid <= spur;
        end
    end

    // Mid-cycle: choose readies for the coming edge and record what it accepts.
    always @(negedge clk) begin
        mem_wready = 1'b1;
        mem_rready = 1'b1;
        if (rand_stall) begin
            mem_wready = ($urandom_range(3, 0) != 0);
            mem_rready = ($urandom_range(3, 0) != 0);
        end
        if (w_left > 0 && mem_wen && n_wacc == w_idx) begin
            mem_wready = 1'b0;
            w_left = w_left - 1;
        end
        if (r_left > 0 && mem_ren && n_racc == r_idx) begin
            mem_rready = 1'b0;
            r_left = r_left - 1;
        end
        spur = spur_idle | (spur_wb & mem_wen);
        if (prev_wstall && !(mem_wen && mem_waddr == pw_addr && mem_wdata == pw_data)) stab_err++;
        if (prev_rstall && !(mem_ren && mem_raddr == pr_addr)) stab_err++;
        prev_wstall = mem_wen && !mem_wready;
        prev_rstall = mem_ren && !mem_rready;
        pw_addr = mem_waddr;
        pw_data = mem_wdata;
        pr_addr = mem_raddr;
        if (prev_wstall) stall_cyc++;
        if (prev_rstall) stall_cyc++;
        if (mem_wen && mem_ren) excl_err++;
        if (cache_wen && cache_ren) excl_err++;
        if (mem_wen && mem_wready) begin wq.push_back({mem_waddr, mem_wdata}); n_wacc++; end
        if (mem_ren && mem_rready) begin rq.push_back(mem_raddr); n_racc++; end
        if (cache_wen) cq.push_back({cache_waddr, cache_wdata});
        if (req_valid && req_ready) begin acc_cnt++; acc_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (!req_ready) busy_cnt++;
    end

    task automatic clear_mon();
        acc_cnt = 0; done_cnt = 0; busy_cnt = 0; stall_cyc = 0;
        n_wacc = 0; n_racc = 0; excl_err = 0; stab_err = 0;
        prev_wstall = 0; prev_rstall = 0;
        w_idx = -1; w_left = 0; r_idx = -1; r_left = 0;
        wq.delete(); rq.delete(); cq.delete();
        exp_wq.delete(); exp_rq.delete(); exp_cq.delete();
        exp_lat = 0;
    endtask

    task automatic set_mem(input int a, input logic [DW-1:0] v);
        mem_arr[a] = v; model_mem[a] = v;
    endtask

    task automatic set_cache(input int a, input logic [DW-1:0] v);
        cache_arr[a] = v; model_cache[a] = v;
    endtask

    task automatic preload_random();
        for (int a = 0; a < MEM_DEPTH; a++) set_mem(a, $urandom);
        for (int a = 0; a < CACHE_DEPTH; a++) set_cache(a, $urandom);
    endtask

    // Reference model: a line operation is the writeback of every victim word
    // (in order), then the fetch of every fill word into the same cache line.
    task automatic build_expect(input int set, input int fl, input bit wb, input int wbl);
        if (wb) begin
            for (int i = 0; i < LW; i++) begin
                exp_wq.push_back({MAW'(wbl * LW + i), model_cache[set * LW + i]});
                model_mem[wbl * LW + i] = model_cache[set * LW + i];
            end
        end
        for (int i = 0; i < LW; i++) begin
            exp_rq.push_back(MAW'(fl * LW + i));
            exp_cq.push_back({CAW'(set * LW + i), model_mem[fl * LW + i]});
            model_cache[set * LW + i] = model_mem[fl * LW + i];
        end
        exp_lat = wb ? (5 * LW + 1) : (2 * LW + 1);
    endtask

    function automatic int seq_diffs();
        int d = 0;
        if (wq.size() != exp_wq.size()) d++;
        else foreach (wq[k]) if (wq[k] !== exp_wq[k]) d++;
        if (rq.size() != exp_rq.size()) d++;
        else foreach (rq[k]) if (rq[k] !== exp_rq[k]) d++;
        if (cq.size() != exp_cq.size()) d++;
        else foreach (cq[k]) if (cq[k] !== exp_cq[k]) d++;
        return d;
    endfunction

    function automatic int arr_diffs();
        int d = 0;
        for (int a = 0; a < MEM_DEPTH; a++) if (mem_arr[a] !== model_mem[a]) d++;
        for (int a = 0; a < CACHE_DEPTH; a++) if (cache_arr[a] !== model_cache[a]) d++;
        return d;
    endfunction

    task automatic drive_req(input int set, input int fl, input bit wb, input int wbl);
        @(posedge clk); #1;
        req_set = SETW'(set); req_fill_line = LINEW'(fl);
        req_wb = wb; req_wb_line = LINEW'(wbl);
        req_valid = 1'b1;
    endtask

    task automatic issue(input int set, input int fl, input bit wb, input int wbl, output bit ok);
        drive_req(set, fl, wb, wbl);
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (acc_cnt > 0) req_valid = 1'b0;
            if (done_cnt > 0) begin ok = 1; break; end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_asserts++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_asserts++;
        if ({done, cache_ren, cache_wen, mem_ren, mem_wen} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 00000", {done, cache_ren, cache_wen, mem_ren, mem_wen});
        end
        n_asserts++;
        if (mem_raddr !== '0 || mem_waddr !== '0 || cache_raddr !== '0) begin
            n_fail++; $display("FAIL reset_addr: got %0d/%0d/%0d expected 0", mem_raddr, mem_waddr, cache_raddr);
        end
        n_asserts++;
        if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_fill();
        bit ok;
        int d;
        clear_mon();
        for (int i = 0; i < LW; i++) set_mem(8 + i, 32'hA0 + i);
        build_expect(1, 2, 0, 0);
        issue(1, 2, 0, 0, ok);
        n_asserts++;
        if (!ok) begin n_fail++; $display("FAIL clean_timeout: got no done expected done"); end
        d = seq_diffs();
        n_asserts++;
        if (d != 0) begin n_fail++; $display("FAIL clean_seq: got %0d diffs expected 0", d); end
        n_asserts++;
        if (done_cyc - acc_cyc != 9) begin n_fail++; $display("FAIL clean_latency: got %0d expected 9", done_cyc - acc_cyc); end
        n_asserts++;
        if (busy_cnt != 9) begin n_fail++; $display("FAIL clean_busy: got %0d expected 9", busy_cnt); end
        d = arr_diffs();
        n_asserts++;
        if (d != 0) begin n_fail++; $display("FAIL clean_arrays: got %0d diffs expected 0", d); end
    endtask

    task automatic test_dirty_evict(input bit bp);
        bit ok;
        int d;
        int lat;
        clear_mon();
        for (int i = 0; i < LW; i++) set_cache(8 + i, 32'h10 + i);
        for (int i = 0; i < LW; i++) set_mem(i, 32'hC0 + i);
        if (bp) begin
            w_idx = 1; w_left = 3; r_idx = 2; r_left = 2;
        end
        build_expect(2, 0, 1, 5);
        lat = exp_lat + (bp ? 5 : 0);
        issue(2, 0, 1, 5, ok);
        n_asserts++;
        if (!ok) begin n_fail++; $display("FAIL evict_timeout bp=%0d: got no done expected done", bp); end
        d = seq_diffs();
        n_asserts++;
        if (d != 0) begin n_fail++; $display("FAIL evict_seq bp=%0d: got %0d diffs expected 0", bp, d); end
        n_asserts++;
        if (done_cyc - acc_cyc != lat) begin
            n_fail++; $display("FAIL evict_latency bp=%0d: got %0d expected %0d", bp, done_cyc - acc_cyc, lat);
        end
        n_asserts++;
        if (excl_err != 0) begin n_fail++; $display("FAIL evict_exclusive bp=%0d: got %0d expected 0", bp, excl_err); end
        n_asserts++;
        if (stab_err != 0) begin n_fail++; $display("FAIL evict_stable bp=%0d: got %0d expected 0", bp, stab_err); end
        d = arr_diffs();
        n_asserts++;
        if (d != 0) begin n_fail++; $display("FAIL evict_arrays bp=%0d: got %0d diffs expected 0", bp, d); end
    endtask

    task automatic test_busy_request();
        bit ok;
        int d;
        clear_mon();
        build_expect(0, 7, 0, 0);
        drive_req(0, 7, 0, 0);
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) begin ok = 1; break; end
        end
        n_asserts++;
        if (!ok) begin n_fail++; $display("FAIL busy_timeout: got no done expected done"); end
        n_asserts++;
        if (acc_cnt != 1) begin n_fail++; $display("FAIL busy_single_accept: got %0d expected 1", acc_cnt); end
        build_expect(0, 7, 0, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_asserts++;
        if (acc_cnt != 2 || acc_cyc != done_cyc + 1) begin
            n_fail++; $display("FAIL busy_second_accept: got cnt %0d offset %0d expected 2 and 1", acc_cnt, acc_cyc - done_cyc);
        end
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (done_cnt > 1) begin ok = 1; break; end
        end
        n_asserts++;
        if (!ok) begin n_fail++; $display("FAIL busy_second_timeout: got no done expected done"); end
        d = seq_diffs();
        n_asserts++;
        if (d != 0) begin n_fail++; $display("FAIL busy_seq: got %0d diffs expected 0", d); end
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        int d;
        clear_mon();
        drive_req(3, 6, 0, 0);
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (acc_cnt > 0) req_valid = 1'b0;
            if (n_racc == 3) begin ok = 1; break; end
        end
        req_valid = 1'b0;
        n_asserts++;
        if (!ok) begin n_fail++; $display("FAIL midrst_reach: got %0d reads expected 3", n_racc); end
        // Now waiting for fill word 2, whose data is valid in this very cycle.
        rst_n = 1'b0;
        #1;
        n_asserts++;
        if ({done, cache_wen, mem_ren} !== 3'b0) begin
            n_fail++; $display("FAIL midrst_strobes: got %b expected 000", {done, cache_wen, mem_ren});
        end
        n_asserts++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", req_ready); end
        n_asserts++;
        if (cq.size() != 2) begin n_fail++; $display("FAIL midrst_partial: got %0d words expected 2", cq.size()); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        build_expect(3, 1, 0, 0);
        issue(3, 1, 0, 0, ok);
        n_asserts++;
        if (!ok) begin n_fail++; $display("FAIL midrst_fresh_timeout: got no done expected done"); end
        d = seq_diffs();
        n_asserts++;
        if (d != 0) begin n_fail++; $display("FAIL midrst_fresh_seq: got %0d diffs expected 0", d); end
        n_asserts++;
        if (done_cyc - acc_cyc != 9) begin n_fail++; $display("FAIL midrst_fresh_latency: got %0d expected 9", done_cyc - acc_cyc); end
        d = arr_diffs();
        n_asserts++;
        if (d != 0) begin n_fail++; $display("FAIL midrst_arrays: got %0d diffs expected 0", d); end
    endtask

    task automatic test_spurious_valid();
        bit ok;
        int d;
        clear_mon();
        @(posedge clk); #1;
        spur_idle = 1;
        @(posedge clk); #1;
        spur_idle = 0;
        n_asserts++;
        if (cache_wen !== 1'b0 || req_ready !== 1'b1 || mem_rdata_valid !== 1'b1) begin
            n_fail++; $display("FAIL spur_idle: got wen %b ready %b valid %b expected 0 1 1", cache_wen, req_ready, mem_rdata_valid);
        end
        @(posedge clk); #1;
        clear_mon();
        spur_wb = 1;
        w_idx = 0; w_left = 3;
        build_expect(1, 3, 1, 6);
        issue(1, 3, 1, 6, ok);
        spur_wb = 0;
        n_asserts++;
        if (!ok) begin n_fail++; $display("FAIL spur_wb_timeout: got no done expected done"); end
        d = seq_diffs();
        n_asserts++;
        if (d != 0) begin n_fail++; $display("FAIL spur_wb_seq: got %0d diffs expected 0", d); end
        n_asserts++;
        if (done_cyc - acc_cyc != exp_lat + 3) begin
            n_fail++; $display("FAIL spur_wb_latency: got %0d expected %0d", done_cyc - acc_cyc, exp_lat + 3);
        end
        d = arr_diffs();
        n_asserts++;
        if (d != 0) begin n_fail++; $display("FAIL spur_wb_arrays: got %0d diffs expected 0", d); end
    endtask

    task automatic test_random();
        bit ok;
        int d, set, fl, wbl;
        bit wb;
        preload_random();
        for (int n = 0; n < 16; n++) begin
            set = $urandom_range(3, 0);
            fl  = $urandom_range(7, 0);
            wbl = $urandom_range(7, 0);
            wb  = 1'($urandom_range(1, 0));
            clear_mon();
            rand_stall = 1;
            build_expect(set, fl, wb, wbl);
            issue(set, fl, wb, wbl, ok);
            rand_stall = 0;
            d = seq_diffs() + (ok ? 0 : 1);
            n_asserts++;
            if (d != 0) begin n_fail++; $display("FAIL rand_seq op %0d: got %0d diffs expected 0", n, d); end
            n_asserts++;
            if (done_cyc - acc_cyc != exp_lat + stall_cyc) begin
                n_fail++; $display("FAIL rand_latency op %0d: got %0d expected %0d", n, done_cyc - acc_cyc, exp_lat + stall_cyc);
            end
            n_asserts++;
            if (excl_err + stab_err != 0) begin
                n_fail++; $display("FAIL rand_protocol op %0d: got %0d errors expected 0", n, excl_err + stab_err);
            end
        end
        d = arr_diffs();
        n_asserts++;
        if (d != 0) begin n_fail++; $display("FAIL rand_arrays: got %0d diffs expected 0", d); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mon();
        preload_random();
        test_reset();
        test_clean_fill();
        test_dirty_evict(0);
        test_dirty_evict(1);
        test_busy_request();
        test_reset_mid_fill();
        test_spurious_valid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/line_fill_ctrl.md
Name: line_fill_ctrl

Overview:
- Cache miss sequencer that owns the fetch-side port of the word-wide memory controller.
- On each accepted miss request it optionally writes back a dirty victim line, word by word, from the cache data array to memory.
- It then refills the line from memory into the cache data array and pulses done.
- Exactly one line operation is in flight at a time.

Parameters:
- MEM_DEPTH, 32, memory depth in words; memory address width MAW = $clog2(MEM_DEPTH).
- DATA_WIDTH, 32, word width.
- LINE_WORDS, 4, words per cache line; power of two, ≥2; OFS = $clog2(LINE_WORDS).
- CACHE_DEPTH, 16, cache data array depth in words; CAW = $clog2(CACHE_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  miss request.
- req_ready  out  1  high only in IDLE.
- req_set  in  CAW-OFS  cache line index (victim and destination).
- req_fill_line  in  MAW-OFS  memory line address to fetch.
- req_wb  in  1  victim is dirty; write it back first.
- req_wb_line  in  MAW-OFS  memory line address of the victim.
- done  out  1  one-cycle pulse: line operation complete.
- cache_ren  out  1  cache array read strobe.
- cache_raddr  out  CAW  cache array read address.
- cache_rdata  in  DATA_WIDTH  cache array read data; valid exactly 1 cycle after cache_ren.
- cache_wen  out  1  cache array write strobe.
- cache_waddr  out  CAW  cache array write address.
- cache_wdata  out  DATA_WIDTH  cache array write data.
- mem_ren  out  1  memory read request.
- mem_raddr  out  MAW  memory read address.
- mem_rready  in  1  read accepted when mem_ren && mem_rready.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_rdata_valid  in  1  read data valid; arrives 1 cycle after acceptance.
- mem_wen  out  1  memory write request.
- mem_waddr  out  MAW  memory write address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wready  in  1  write accepted when mem_wen && mem_wready.

Behaviour:
- Reset values: state = IDLE, word counter = 0, all registers = 0. All strobes, including done, are 0. req_ready = 1.
- Request capture: on req_valid && req_ready, register set, fill line, wb flag and wb line. The next state is WB_RD if req_wb = 1, otherwise FILL_REQ.
- Address formation, word index i = 0..LINE_WORDS-1:
  - cache address = {set, i}
  - memory address = {line, i}
  - i is a register, cleared on leaving IDLE and on the transition from writeback to fill.
- WB_RD: cache_ren = 1, cache_raddr = {set, i}. Next state WB_LAT.
- WB_LAT: latch cache_rdata into wb_data. Next state WB_WR.
- WB_WR:
  - mem_wen = 1, mem_waddr = {wb_line, i}, mem_wdata = wb_data.
  - While mem_wready = 0, hold all three stable.
  - On acceptance, if i = LINE_WORDS-1: clear i, next state FILL_REQ.
  - Otherwise: i++, next state WB_RD.
- FILL_REQ:
  - mem_ren = 1, mem_raddr = {fill_line, i}.
  - While mem_rready = 0, hold mem_ren and mem_raddr stable.
  - On acceptance, next state FILL_WAIT.
- FILL_WAIT:
  - mem_ren = 0. Wait for mem_rdata_valid.
  - In the valid cycle: cache_wen = 1, cache_waddr = {set, i}, cache_wdata = mem_rdata (combinational pass-through).
  - Then, if i = LINE_WORDS-1: next state DONE. Otherwise: i++, next state FILL_REQ.
- DONE: done = 1 for one cycle. Next state IDLE.
- Mutual exclusion: mem_ren and mem_wen are never high together. cache_ren and cache_wen are never high together.
- Latency, zero stall:
  - Writeback: 3 cycles per word.
  - Fill: 2 cycles per word.
  - done is asserted in cycle 2·LINE_WORDS+1 after acceptance with no writeback, or 5·LINE_WORDS+1 with writeback.
- Requests presented while busy are not accepted; req_ready = 0 outside IDLE.
- mem_rdata_valid outside FILL_WAIT is ignored.
- Reset mid-operation: everything returns to reset values immediately, and the partial transfer is abandoned. The cache line contents are then undefined; the cache tag logic must invalidate the set.
- The address counter wraps only via the explicit clear; it is never allowed to overflow into the set field.

Test Plan:
- Clean fill, req_wb=0, set=1, fill_line=2, memory words 8..11 = 0xA0..0xA3, rready=1 → mem_raddr sequence 8,9,10,11; cache writes addr 4..7 data 0xA0..0xA3; done in cycle 9 after acceptance; req_ready low cycles 1..9.
- Dirty evict, req_wb=1, wb_line=5, set=2, cache words 8..11 = 0x10..0x13, fill_line=0 → mem writes addr 20..23 data 0x10..0x13, then fill reads 0..3 into cache 8..11; done in cycle 21; no cycle with mem_ren and mem_wen both high.
- Backpressure: mem_wready=0 for 3 cycles on word 1, then mem_rready=0 for 2 cycles on fill word 2 → mem_wen/mem_waddr/mem_wdata and mem_ren/mem_raddr held stable throughout; final memory and cache contents as in the dirty-evict test; done delayed by exactly 5 cycles.
- Busy request: req_valid held high from acceptance through done → only one acceptance; second accepted in the cycle after done (IDLE).
- Reset mid-fill: rst_n low during FILL_WAIT of word 2 → done, cache_wen, mem_ren all 0 immediately; req_ready=1; fresh request after reset completes normally with correct addresses from word 0.
- Spurious valid: mem_rdata_valid pulsed in IDLE and WB_WR → no cache_wen, state unaffected.
